fsm_input_conditioner: RTL and testbench

FSM_INPUT_CONDITIONER -- requirements
Module: fsm_input_conditioner

---
 rtl/fsm_input_conditioner.sv | 112 +++++++++++
 tb/tb_fsm_input_conditioner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_input_conditioner.sv
// ============================================================================
//  Module   : fsm_input_conditioner
//  Purpose  : Conditions two asynchronous, bouncing push-button levels for a
//             downstream sequencing FSM. Each input is synchronized by two
//             flops and then debounced by a per-channel hold counter. The "go"
//             channel is presented as a debounced level. The "jmp" channel is
//             presented as a one-cycle pulse on each debounced rising edge,
//             and those pulses are counted.
//  Ports    : clk      - single clock, rising-edge active
//             rst      - asynchronous active-high reset
//             go_raw   - raw "go" button level (asynchronous, bouncing)
//             jmp_raw  - raw "jmp" button level (asynchronous, bouncing)
//             go       - debounced go level (registered)
//             jmp      - single-cycle pulse per debounced jmp press (registered)
//             jmp_cnt  - 8-bit wrapping count of jmp pulses since reset
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_raw,
  input  logic       jmp_raw,
  output logic       go,
  output logic       jmp,
  output logic [7:0] jmp_cnt
);

  // Counter value at which a disagreeing level is accepted. The counter
  // counts disagreeing cycles 0..DEBOUNCE_CYCLES-1, so the new level is
  // taken on the DEBOUNCE_CYCLES-th consecutive disagreeing edge.
  localparam logic [7:0] C_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = go, channel 1 = jmp.
  logic [1:0] w_raw;
  logic [1:0] w_db;

  assign w_raw = {jmp_raw, go_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic       sync1_q;
    logic       sync2_q;
    logic       db_q;
    logic       db_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        cnt_q   <= 8'd0;
      end else begin
        sync1_q <= w_raw[g];
        sync2_q <= sync1_q;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
      end
    end

    // Any cycle where the synchronized level agrees with the debounced
    // level restarts the qualification window from zero.
    always_comb begin
      db_d  = db_q;
      cnt_d = 8'd0;
      if (sync2_q != db_q) begin
        if (cnt_q == C_CNT_LAST) begin
          db_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    assign w_db[g] = db_q;
  end

  // jmp edge detector: remembers last cycle's debounced jmp level so that
  // only a 0->1 change of the debounced level produces a pulse.
  logic       jmp_db_prev_q;
  logic       jmp_q;
  logic [7:0] jmp_cnt_q;
  logic       w_jmp_rise;

  assign w_jmp_rise = w_db[1] & ~jmp_db_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jmp_db_prev_q <= 1'b0;
      jmp_q         <= 1'b0;
      jmp_cnt_q     <= 8'd0;
    end else begin
      jmp_db_prev_q <= w_db[1];
      jmp_q         <= w_jmp_rise;
      // Free-running 8-bit count; wraps 255 -> 0 by design.
      if (w_jmp_rise) begin
        jmp_cnt_q <= jmp_cnt_q + 8'd1;
      end
    end
  end

  assign go      = w_db[0];
  assign jmp     = jmp_q;
  assign jmp_cnt = jmp_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_input_conditioner.sv
// ============================================================================
//  Module   : tb_fsm_input_conditioner
//  Purpose  : Self-checking bench for fsm_input_conditioner. Directed
//             scenarios check absolute edge timing; a randomized run is
//             compared against a window-based reference model of the
//             synchronize/debounce/pulse behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_input_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       go_raw;
  logic       jmp_raw;
  logic       go;
  logic       jmp;
  logic [7:0] jmp_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  fsm_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .go_raw  (go_raw),
    .jmp_raw (jmp_raw),
    .go      (go),
    .jmp     (jmp),
    .jmp_cnt (jmp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model. Raw levels seen at each edge since reset are kept in a
  // history. The synchronized level presented at edge k is the raw level of
  // edge k-2. The debounced level flips at edge n exactly when the D most
  // recent synchronized levels (edges n-D+1..n) all differ from it.
  // --------------------------------------------------------------------------
  bit       hist_go[$];
  bit       hist_jmp[$];
  int       n_edge;
  bit       m_db_go, m_db_jmp, m_rose, m_jmp;
  bit [7:0] m_cnt;

  function automatic bit s2_at(input int ch, input int k);
    if (k < 3) return 1'b0;
    return (ch == 0) ? hist_go[k-3] : hist_jmp[k-3];
  endfunction

  function automatic bit qualifies(input int ch, input bit cur);
    for (int k = n_edge - D + 1; k <= n_edge; k++)
      if (s2_at(ch, k) == cur) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    hist_go.delete();
    hist_jmp.delete();
    n_edge   = 0;
    m_db_go  = 0;
    m_db_jmp = 0;
    m_rose   = 0;
    m_jmp    = 0;
    m_cnt    = 0;
  endtask

  task automatic model_edge();
    bit new_go, new_jmp;
    n_edge++;
    hist_go.push_back(go_raw);
    hist_jmp.push_back(jmp_raw);
    m_jmp = m_rose;
    if (m_jmp) m_cnt = m_cnt + 8'd1;
    new_go  = qualifies(0, m_db_go)  ? ~m_db_go  : m_db_go;
    new_jmp = qualifies(1, m_db_jmp) ? ~m_db_jmp : m_db_jmp;
    m_rose   = ~m_db_jmp & new_jmp;
    m_db_go  = new_go;
    m_db_jmp = new_jmp;
  endtask

  // Drive raw levels, advance one rising edge, update the model, settle.
  task automatic step(input bit g, input bit j);
    go_raw  = g;
    jmp_raw = j;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Hold reset over two clock edges, then release at a falling edge so the
  // next rising edge is edge 1.
  task automatic do_reset(input bit g, input bit j);
    rst     = 1'b1;
    go_raw  = g;
    jmp_raw = j;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst     = 1'b1;
    go_raw  = 1'b1;
    jmp_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({go, jmp, jmp_cnt} !== 10'd0)
      $display("FAIL reset_outputs: got go=%0b jmp=%0b jmp_cnt=%0d, want all 0", go, jmp, jmp_cnt);
    else n_pass++;
    n_checks++;
    if ({dut.g_ch[0].sync2_q, dut.g_ch[1].sync2_q, dut.g_ch[0].cnt_q} !== 10'd0)
      $display("FAIL reset_state: got sync2=%0b%0b cnt=%0d, want 0", dut.g_ch[1].sync2_q,
               dut.g_ch[0].sync2_q, dut.g_ch[0].cnt_q);
    else n_pass++;
  endtask

  task automatic test_go_latency();
    do_reset(1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if ({go, jmp} !== {(e >= D + 2), 1'b0})
        $display("FAIL go_latency edge %0d: got go=%0b jmp=%0b, want go=%0b jmp=0", e, go, jmp, e >= D + 2);
      else n_pass++;
    end
    // falling transition has the same latency
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (go !== (e < D + 2))
        $display("FAIL go_fall edge %0d: got go=%0b, want %0b", e, go, e < D + 2);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    do_reset(1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    repeat (D - 1) step(1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (go !== 1'b0)
        $display("FAIL glitch_go edge %0d: got go=%0b, want 0", e, go);
      else n_pass++;
    end
    n_checks++;
    if (dut.g_ch[0].cnt_q !== 8'd0)
      $display("FAIL glitch_cnt: got cnt=%0d, want 0", dut.g_ch[0].cnt_q);
    else n_pass++;
  endtask

  task automatic test_jmp_single();
    int pulses = 0;
    do_reset(1'b0, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b1);
      if (jmp === 1'b1) pulses++;
      n_checks++;
      if ({jmp, jmp_cnt} !== {(e == D + 3), ((e >= D + 3) ? 8'd1 : 8'd0)})
        $display("FAIL jmp_press edge %0d: got jmp=%0b cnt=%0d, want jmp=%0b cnt=%0d",
                 e, jmp, jmp_cnt, e == D + 3, (e >= D + 3) ? 1 : 0);
      else n_pass++;
    end
    for (int e = 1; e <= 15; e++) begin
      step(1'b0, 1'b0);
      if (jmp === 1'b1) pulses++;
    end
    n_checks++;
    if ({pulses == 1, jmp_cnt} !== {1'b1, 8'd1})
      $display("FAIL jmp_release: got pulses=%0d cnt=%0d, want pulses=1 cnt=1", pulses, jmp_cnt);
    else n_pass++;
  endtask

  task automatic test_jmp_wrap();
    int total = 0;
    int width;
    do_reset(1'b0, 1'b0);
    for (int p = 0; p < 256; p++) begin
      width = 0;
      repeat (8) begin
        step(1'b0, 1'b1);
        if (jmp === 1'b1) width++;
      end
      repeat (8) begin
        step(1'b0, 1'b0);
        if (jmp === 1'b1) width++;
      end
      total += width;
      n_checks++;
      if (width != 1)
        $display("FAIL wrap_pulse_width press %0d: got %0d high cycles, want 1", p, width);
      else n_pass++;
    end
    n_checks++;
    if ({total == 256, jmp_cnt} !== {1'b1, 8'd0})
      $display("FAIL wrap_count: got pulses=%0d cnt=%0d, want pulses=256 cnt=0", total, jmp_cnt);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if ({go, jmp} !== {(e >= D + 2), (e == D + 3)})
        $display("FAIL simultaneous edge %0d: got go=%0b jmp=%0b, want go=%0b jmp=%0b",
                 e, go, jmp, e >= D + 2, e == D + 3);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    // partial jmp qualification followed by go reaching 1
    do_reset(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (7) step(1'b1, 1'b1);
    n_checks++;
    if (go !== 1'b1)
      $display("FAIL reset_mid_pre: got go=%0b, want 1", go);
    else n_pass++;
    // 5 ns reset pulse entirely between clock edges
    rst = 1'b1;
    #1;
    n_checks++;
    if ({go, jmp, jmp_cnt} !== 10'd0)
      $display("FAIL reset_async: got go=%0b jmp=%0b cnt=%0d, want all 0", go, jmp, jmp_cnt);
    else n_pass++;
    #4;
    rst = 1'b0;
    model_clear();
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if ({go, jmp, jmp_cnt} !== {(e >= D + 2), (e == D + 3), ((e >= D + 3) ? 8'd1 : 8'd0)})
        $display("FAIL reset_mid_post edge %0d: got go=%0b jmp=%0b cnt=%0d", e, go, jmp, jmp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int  hold_g = 0, hold_j = 0;
    bit  lv_g = 0, lv_j = 0;
    int  errs = 0;
    do_reset(1'b0, 1'b0);
    for (int e = 1; e <= 2500; e++) begin
      if (hold_g == 0) begin lv_g = 1'($urandom_range(0, 1)); hold_g = $urandom_range(1, 8); end
      if (hold_j == 0) begin lv_j = 1'($urandom_range(0, 1)); hold_j = $urandom_range(1, 8); end
      hold_g--;
      hold_j--;
      step(lv_g, lv_j);
      n_checks++;
      if ({go, jmp, jmp_cnt} !== {m_db_go, m_jmp, m_cnt}) begin
        if (errs < 10)
          $display("FAIL random edge %0d: got go=%0b jmp=%0b cnt=%0d, want go=%0b jmp=%0b cnt=%0d",
                   e, go, jmp, jmp_cnt, m_db_go, m_jmp, m_cnt);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    go_raw  = 1'b0;
    jmp_raw = 1'b0;
    model_clear();
    test_reset();
    test_go_latency();
    test_glitch();
    test_jmp_single();
    test_jmp_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
